// File: rtl/controle_elevador.sv
// controle_elevador: car-level elevator sequencer.
// Latches floor calls, picks the travel direction with a keep-direction (SCAN)
// policy, steps the car one floor every T_VIAGEM cycles and runs the door
// open/close cycle. The cheio input holds the door open or reopens it.
module controle_elevador #(
    parameter int N_ANDARES = 4,
    parameter int T_VIAGEM  = 16,
    parameter int T_PORTA   = 8,
    parameter int T_FECHA   = 2,
    localparam int W_ANDAR  = $clog2(N_ANDARES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_ANDARES-1:0] chamada,
    input  logic                 cheio,
    output logic [W_ANDAR-1:0]   andar_atual,
    output logic                 subindo,
    output logic                 descendo,
    output logic                 porta_aberta,
    output logic                 porta_fechada,
    output logic [N_ANDARES-1:0] pendentes,
    output logic                 ocupado
);

    localparam int T_MAX0 = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
    localparam int T_MAX  = (T_MAX0 > T_FECHA) ? T_MAX0 : T_FECHA;
    localparam int TW     = $clog2(T_MAX);

    localparam logic [TW-1:0]      FIM_VIAGEM = TW'(T_VIAGEM - 1);
    localparam logic [TW-1:0]      FIM_PORTA  = TW'(T_PORTA - 1);
    localparam logic [TW-1:0]      FIM_FECHA  = TW'(T_FECHA - 1);
    localparam logic [TW-1:0]      UM_T       = TW'(1);
    localparam logic [W_ANDAR-1:0] TOPO       = W_ANDAR'(N_ANDARES - 1);
    localparam logic [W_ANDAR-1:0] UM_ANDAR   = W_ANDAR'(1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        OPEN,
        CLOSE
    } estado_t;

    estado_t              estado, estado_prox;
    logic [TW-1:0]        timer, timer_prox;
    logic                 dir, dir_prox;
    logic [W_ANDAR-1:0]   andar_prox;
    logic [N_ANDARES-1:0] pend_prox;
    logic                 acima, abaixo, dir_escolha;
    logic                 chamada_aqui;

    // State, timer, direction, floor and pending-call registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= IDLE;
            timer       <= '0;
            dir         <= 1'b1;
            andar_atual <= '0;
            pendentes   <= '0;
        end else begin
            estado      <= estado_prox;
            timer       <= timer_prox;
            dir         <= dir_prox;
            andar_atual <= andar_prox;
            pendentes   <= pend_prox;
        end
    end

    // Direction rule: keep going up while calls remain above, else prefer down.
    always_comb begin
        acima  = 1'b0;
        abaixo = 1'b0;
        for (int unsigned i = 0; i < N_ANDARES; i++) begin
            if (pendentes[i] && (W_ANDAR'(i) > andar_atual)) acima  = 1'b1;
            if (pendentes[i] && (W_ANDAR'(i) < andar_atual)) abaixo = 1'b1;
        end
        dir_escolha = (dir && acima) || !abaixo;
    end

    // Next-state, timer, floor stepping and call latching/clearing.
    always_comb begin
        estado_prox  = estado;
        timer_prox   = timer + UM_T;
        dir_prox     = dir;
        andar_prox   = andar_atual;
        chamada_aqui = chamada[andar_atual];
        pend_prox    = pendentes | chamada;

        case (estado)
            IDLE: begin
                timer_prox = '0;
                if (pendentes[andar_atual]) begin
                    estado_prox               = OPEN;
                    pend_prox[andar_atual]    = 1'b0;
                end else if (|pendentes) begin
                    estado_prox = MOVE;
                    dir_prox    = dir_escolha;
                end
            end
            MOVE: begin
                if (timer == FIM_VIAGEM) begin
                    timer_prox = '0;
                    if (dir && (andar_atual != TOPO))
                        andar_prox = andar_atual + UM_ANDAR;
                    else if (!dir && (andar_atual != '0))
                        andar_prox = andar_atual - UM_ANDAR;
                    // Arrival check uses the registered vector; a same-cycle
                    // call to the arrival floor is absorbed by the clear.
                    if (pendentes[andar_prox]) begin
                        estado_prox           = OPEN;
                        pend_prox[andar_prox] = 1'b0;
                    end
                end
            end
            OPEN: begin
                pend_prox[andar_atual] = pendentes[andar_atual];
                if (cheio || chamada_aqui) begin
                    timer_prox = '0;
                end else if (timer == FIM_PORTA) begin
                    estado_prox = CLOSE;
                    timer_prox  = '0;
                end
            end
            CLOSE: begin
                pend_prox[andar_atual] = pendentes[andar_atual];
                if (cheio || chamada_aqui) begin
                    estado_prox = OPEN;
                    timer_prox  = '0;
                end else if (timer == FIM_FECHA) begin
                    timer_prox = '0;
                    if (|pendentes) begin
                        estado_prox = MOVE;
                        dir_prox    = dir_escolha;
                    end else begin
                        estado_prox = IDLE;
                    end
                end
            end
            default: begin
                estado_prox = IDLE;
                timer_prox  = '0;
            end
        endcase
    end

    assign subindo       = (estado == MOVE) && dir;
    assign descendo      = (estado == MOVE) && !dir;
    assign porta_aberta  = (estado == OPEN);
    assign porta_fechada = (estado == IDLE) || (estado == MOVE);
    assign ocupado       = (estado != IDLE);

endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador: directed scenarios with literal expectations
// plus a per-cycle comparison against a countdown-based behavioural model.
module tb_controle_elevador;

    localparam int N  = 4;
    localparam int TV = 16;
    localparam int TP = 8;
    localparam int TF = 2;
    localparam int W  = $clog2(N);

    localparam int F_PARADO   = 0;
    localparam int F_VIAGEM   = 1;
    localparam int F_ABERTA   = 2;
    localparam int F_FECHANDO = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] chamada;
    logic         cheio;
    logic [W-1:0] andar_atual;
    logic         subindo, descendo, porta_aberta, porta_fechada, ocupado;
    logic [N-1:0] pendentes;

    int checks = 0;
    int errors = 0;

    controle_elevador #(
        .N_ANDARES(N),
        .T_VIAGEM(TV),
        .T_PORTA(TP),
        .T_FECHA(TF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chamada(chamada),
        .cheio(cheio),
        .andar_atual(andar_atual),
        .subindo(subindo),
        .descendo(descendo),
        .porta_aberta(porta_aberta),
        .porta_fechada(porta_fechada),
        .pendentes(pendentes),
        .ocupado(ocupado)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Behavioural model: phase + cycles remaining in it, floor as an int.
    typedef struct packed {
        int           andar;
        bit           sobe;
        int           fase;
        int           resta;
        logic [N-1:0] pend;
    } modelo_t;

    function automatic modelo_t passo(modelo_t m, logic [N-1:0] ch, logic full);
        modelo_t r;
        bit acima, abaixo;
        r = m;
        acima = 0;
        abaixo = 0;
        for (int i = 0; i < N; i++) begin
            if (m.pend[i] && i > m.andar) acima = 1;
            if (m.pend[i] && i < m.andar) abaixo = 1;
        end
        r.pend = m.pend | ch;
        if (m.fase == F_ABERTA || m.fase == F_FECHANDO) r.pend[m.andar] = m.pend[m.andar];
        case (m.fase)
            F_PARADO: begin
                if (m.pend[m.andar]) begin
                    r.fase = F_ABERTA; r.resta = TP - 1; r.pend[m.andar] = 1'b0;
                end else if (m.pend != 0) begin
                    r.fase = F_VIAGEM; r.resta = TV - 1;
                    r.sobe = (m.sobe && acima) ? 1'b1 : (abaixo ? 1'b0 : 1'b1);
                end
            end
            F_VIAGEM: begin
                if (m.resta == 0) begin
                    if (m.sobe && m.andar < N - 1) r.andar = m.andar + 1;
                    if (!m.sobe && m.andar > 0) r.andar = m.andar - 1;
                    r.resta = TV - 1;
                    if (m.pend[r.andar]) begin
                        r.fase = F_ABERTA; r.resta = TP - 1; r.pend[r.andar] = 1'b0;
                    end
                end else r.resta = m.resta - 1;
            end
            F_ABERTA: begin
                if (full || ch[m.andar]) r.resta = TP - 1;
                else if (m.resta == 0) begin r.fase = F_FECHANDO; r.resta = TF - 1; end
                else r.resta = m.resta - 1;
            end
            default: begin
                if (full || ch[m.andar]) begin
                    r.fase = F_ABERTA; r.resta = TP - 1;
                end else if (m.resta == 0) begin
                    if (m.pend != 0) begin
                        r.fase = F_VIAGEM; r.resta = TV - 1;
                        r.sobe = (m.sobe && acima) ? 1'b1 : (abaixo ? 1'b0 : 1'b1);
                    end else r.fase = F_PARADO;
                end else r.resta = m.resta - 1;
            end
        endcase
        return r;
    endfunction

    modelo_t m;

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{andar: 0, sobe: 1'b1, fase: F_PARADO, resta: 0, pend: '0};
        else       m <= passo(m, chamada, cheio);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [10:0] esp, obt;
        logic [W-1:0] a;
        a = m.andar[W-1:0];
        esp = {a, (m.fase == F_VIAGEM) && m.sobe, (m.fase == F_VIAGEM) && !m.sobe,
               m.fase == F_ABERTA, (m.fase == F_PARADO) || (m.fase == F_VIAGEM),
               m.fase != F_PARADO, m.pend};
        obt = {andar_atual, subindo, descendo, porta_aberta, porta_fechada, ocupado, pendentes};
        check("model", 32'(obt), 32'(esp));
    end

    function automatic logic sinal(input int k);
        case (k)
            0: return subindo;
            1: return descendo;
            2: return porta_aberta;
            3: return ocupado && !porta_aberta && !porta_fechada;
            default: return ocupado;
        endcase
    endfunction

    task automatic enquanto(input int k, output int n);
        n = 0;
        while (sinal(k) && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic espera(input int k, input logic v, input string nome);
        int n = 0;
        while (sinal(k) !== v && n < 500) begin
            n++;
            @(negedge clk);
        end
        check(nome, 32'(sinal(k)), 32'(v));
    endtask

    task automatic pulso(input logic [N-1:0] v);
        chamada = v;
        @(negedge clk);
        chamada = '0;
    endtask

    task automatic checa_repouso(input string nome, input logic [W-1:0] andar);
        check({nome, "_andar"}, 32'(andar_atual), 32'(andar));
        check({nome, "_decod"}, {27'd0, subindo, descendo, porta_aberta, porta_fechada, ocupado}, 32'b00010);
        check({nome, "_pend"}, 32'(pendentes), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        bit desc_visto;
        reset = 1'b1;
        chamada = '0;
        cheio = 1'b0;
        #1;
        checa_repouso("reset", 2'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checa_repouso("idle20", 2'd0);

        // Single trip 0 -> 2
        chamada = 4'b0100;
        @(negedge clk);
        chamada = '0;
        check("trip_latch", 32'(pendentes), 32'b0100);
        @(negedge clk);
        enquanto(0, n);
        check("trip_up_cycles", n, 32);
        check("trip_floor", 32'(andar_atual), 2);
        enquanto(2, n);
        check("trip_open_cycles", n, 8);
        enquanto(3, n);
        check("trip_close_cycles", n, 2);
        checa_repouso("trip_end", 2'd2);

        // SCAN: go to 0, then head for 3 and call 0 while passing floor 1
        pulso(4'b0001);
        espera(4, 1'b1, "scan_start");
        espera(4, 1'b0, "scan_home");
        check("scan_home_floor", 32'(andar_atual), 0);
        pulso(4'b1000);
        repeat (19) @(negedge clk);
        check("scan_at1", 32'({andar_atual, subindo}), 32'({2'd1, 1'b1}));
        pulso(4'b0001);
        check("scan_pend", 32'(pendentes), 32'b1001);
        desc_visto = 0;
        n = 0;
        while (!porta_aberta && n < 500) begin
            if (descendo) desc_visto = 1;
            n++;
            @(negedge clk);
        end
        check("scan_first_stop", 32'(andar_atual), 3);
        check("scan_no_early_down", 32'(desc_visto), 0);
        espera(1, 1'b1, "scan_reverse");
        check("scan_reverse_floor", 32'(andar_atual), 3);
        espera(2, 1'b1, "scan_second_open");
        check("scan_second_stop", 32'(andar_atual), 0);
        espera(4, 1'b0, "scan_done");
        checa_repouso("scan_end", 2'd0);

        // Overload hold
        cheio = 1'b1;
        pulso(4'b0001);
        @(negedge clk);
        n = 0;
        repeat (50) begin
            if (porta_aberta) n++;
            @(negedge clk);
        end
        check("hold_open50", n, 50);
        cheio = 1'b0;
        enquanto(2, n);
        check("hold_release_cycles", n, 8);
        espera(4, 1'b0, "hold_done");

        // Reopen on first CLOSE cycle
        pulso(4'b0001);
        @(negedge clk);
        espera(2, 1'b0, "reopen_close");
        check("reopen_is_close", 32'(sinal(3)), 1);
        cheio = 1'b1;
        @(negedge clk);
        cheio = 1'b0;
        check("reopen_open", 32'(porta_aberta), 1);
        enquanto(2, n);
        check("reopen_open_cycles", n, 8);
        enquanto(3, n);
        check("reopen_close_cycles", n, 2);
        checa_repouso("reopen_end", 2'd0);

        // Same-floor call in IDLE: open without moving
        pulso(4'b0001);
        check("same_latch", 32'({pendentes, ocupado}), 32'({4'b0001, 1'b0}));
        @(negedge clk);
        check("same_open", 32'({porta_aberta, subindo, descendo, pendentes}), 32'({3'b100, 4'b0000}));
        espera(4, 1'b0, "same_done");

        // Call to the arrival floor on the arrival cycle is absorbed
        pulso(4'b0100);
        repeat (32) @(negedge clk);
        check("arr_last_move", 32'({andar_atual, subindo}), 32'({2'd1, 1'b1}));
        chamada = 4'b0100;
        @(negedge clk);
        chamada = '0;
        check("arr_open", 32'({andar_atual, porta_aberta, pendentes}), 32'({2'd2, 1'b1, 4'b0000}));
        espera(4, 1'b0, "arr_done");
        repeat (5) @(negedge clk);
        checa_repouso("arr_no_second", 2'd2);

        // Reset mid-MOVE
        pulso(4'b0001);
        repeat (20) @(negedge clk);
        check("rst_moving", 32'({andar_atual, descendo}), 32'({2'd1, 1'b1}));
        #2 reset = 1'b1;
        #1;
        checa_repouso("rst_mid", 2'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checa_repouso("rst_after", 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
